// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control: walks fetch/decode/execute/memory/writeback
// for one instruction at a time and drives the ALU, operand muxes and memory.
module mips_mc_control #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_op,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC_R  = 4'd6,
    ALUWB_R = 4'd7,
    EXEC_I  = 4'd8,
    ALUWB_I = 4'd9,
    BRANCH  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  localparam logic [OP_W-1:0] FN_ADD = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] FN_SUB = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] FN_AND = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] FN_OR  = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] FN_SLT = OP_W'(6'b101010);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4'b0011);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4'b0100);

  state_t cur_state, nxt_state;

  // Raw strobes before the reset gate; the gate keeps writes off while reset_n is low.
  logic pc_en_raw, ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cur_state <= FETCH;
    else          cur_state <= nxt_state;
  end

  // Memory handshake: mem_read/mem_write are held steady for as long as the
  // FSM sits in FETCH/MEMRD/MEMWR; the access completes in the cycle mem_ready=1.
  always_comb begin
    nxt_state     = FETCH;
    pc_en_raw     = 1'b0;
    pc_src        = 2'b00;
    ir_write_raw  = 1'b0;
    mem_read      = 1'b0;
    mem_write_raw = 1'b0;
    iord          = 1'b0;
    reg_write_raw = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_op        = 1'b0;
    alu_op        = ALU_ADD;
    illegal_raw   = 1'b0;
    case (cur_state)
      FETCH: begin
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        pc_en_raw    = mem_ready;
        ir_write_raw = mem_ready;
        nxt_state    = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 1'b1;
        case (opcode)
          OP_LW, OP_SW:    nxt_state = MEMADR;
          OP_BEQ:          nxt_state = BRANCH;
          OP_ADDI, OP_ORI: nxt_state = EXEC_I;
          OP_J:            nxt_state = JUMP;
          OP_R: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: nxt_state = EXEC_R;
              default: illegal_raw = 1'b1;
            endcase
          end
          default: illegal_raw = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
        nxt_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        nxt_state = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      MEMWR: begin
        mem_write_raw = 1'b1;
        iord          = 1'b1;
        nxt_state     = mem_ready ? FETCH : MEMWR;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
        nxt_state = ALUWB_R;
      end
      ALUWB_R: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_ORI) begin
          ext_op = 1'b0;
          alu_op = ALU_OR;
        end else begin
          ext_op = 1'b1;
          alu_op = ALU_ADD;
        end
        nxt_state = ALUWB_I;
      end
      ALUWB_I: reg_write_raw = 1'b1;
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_en_raw = zero;
      end
      JUMP: begin
        pc_src    = 2'b10;
        pc_en_raw = 1'b1;
      end
      default: nxt_state = FETCH;
    endcase
  end

  assign pc_en     = pc_en_raw     & reset_n;
  assign ir_write  = ir_write_raw  & reset_n;
  assign mem_write = mem_write_raw & reset_n;
  assign reg_write = reg_write_raw & reset_n;
  assign illegal   = illegal_raw   & reset_n;
  assign state     = cur_state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: per-cycle expected control words are queued as
// each cycle is driven and compared against the DUT outputs mid-cycle.
module tb_mips_mc_control;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_en, ir_write, mem_read, mem_write, iord, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, ext_op, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_op, state;

  logic [22:0] exp_q[$];
  logic [22:0] obs;
  int          n_checks = 0;
  int          n_errors = 0;
  int          rw_cnt = 0;

  mips_mc_control #(.OP_W(6), .ALUOP_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_op(ext_op), .alu_op(alu_op), .illegal(illegal), .state(state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  assign obs = {state, pc_en, pc_src, ir_write, mem_read, mem_write, iord,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op,
                alu_op, illegal};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] mk(
    input logic [3:0] st, input logic pce, input logic [1:0] psrc,
    input logic irw, input logic mrd, input logic mwr, input logic io,
    input logic rw, input logic rd, input logic m2r, input logic a,
    input logic [1:0] b, input logic ext, input logic [3:0] op, input logic ill);
    return {st, pce, psrc, irw, mrd, mwr, io, rw, rd, m2r, a, b, ext, op, ill};
  endfunction

  // Expected control word for each state, straight from the state table.
  function automatic logic [22:0] e_fetch(input logic rdy);
    return mk(4'd0, rdy, 2'b00, rdy, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 4'b0000, 0);
  endfunction
  function automatic logic [22:0] e_decode(input logic ill);
    return mk(4'd1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 4'b0000, ill);
  endfunction
  function automatic logic [22:0] e_memadr();
    return mk(4'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 4'b0000, 0);
  endfunction
  function automatic logic [22:0] e_memrd();
    return mk(4'd3, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 0);
  endfunction
  function automatic logic [22:0] e_memwb();
    return mk(4'd4, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 4'b0000, 0);
  endfunction
  function automatic logic [22:0] e_memwr();
    return mk(4'd5, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 0);
  endfunction
  function automatic logic [22:0] e_exec_r(input logic [3:0] op);
    return mk(4'd6, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, op, 0);
  endfunction
  function automatic logic [22:0] e_aluwb_r();
    return mk(4'd7, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 4'b0000, 0);
  endfunction
  function automatic logic [22:0] e_exec_i(input logic ext, input logic [3:0] op);
    return mk(4'd8, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ext, op, 0);
  endfunction
  function automatic logic [22:0] e_aluwb_i();
    return mk(4'd9, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 4'b0000, 0);
  endfunction
  function automatic logic [22:0] e_branch(input logic z);
    return mk(4'd10, z, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 4'b0001, 0);
  endfunction
  function automatic logic [22:0] e_jump();
    return mk(4'd11, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 0);
  endfunction

  // Driver: apply one cycle of inputs, queue the expected word, compare mid-cycle.
  task automatic cycle(input string tag, input logic rdy, input logic z, input logic [22:0] e);
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
    @(negedge clock);
    if (reg_write) rw_cnt++;
    check_val(tag, 32'(obs), 32'(exp_q.pop_front()));
    @(posedge clock);
    #1;
  endtask

  function automatic logic rz();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_fetch(input int stalls);
    for (int i = 0; i < stalls; i++) cycle("fetch_wait", 1'b0, rz(), e_fetch(1'b0));
    cycle("fetch", 1'b1, rz(), e_fetch(1'b1));
  endtask

  task automatic run_r(input logic [5:0] fn, input logic [3:0] op, input int stalls);
    opcode = 6'b000000;
    funct  = fn;
    do_fetch(stalls);
    cycle("r_decode", 1'b1, rz(), e_decode(1'b0));
    cycle("r_exec", 1'b1, rz(), e_exec_r(op));
    cycle("r_wb", 1'b1, rz(), e_aluwb_r());
  endtask

  typedef struct packed {
    logic [5:0] fn;
    logic [3:0] op;
  } r_vec_t;

  r_vec_t r_tab[5];

  initial begin
    r_tab[0] = '{6'b100000, 4'b0000};
    r_tab[1] = '{6'b100010, 4'b0001};
    r_tab[2] = '{6'b100100, 4'b0010};
    r_tab[3] = '{6'b100101, 4'b0011};
    r_tab[4] = '{6'b101010, 4'b0100};

    reset_n   = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    opcode    = 6'b000000;
    funct     = 6'b100000;

    // In reset with mem_ready high: FETCH values, strobes forced low.
    @(negedge clock);
    check_val("reset_out", 32'(obs), 32'(e_fetch(1'b0)));
    @(posedge clock);
    #1;
    check_val("reset_hold", 32'(state), 32'd0);
    reset_n = 1'b1;

    // R-type add straight out of reset, then back in FETCH on cycle 5
    run_r(6'b100000, 4'b0000, 0);

    // All R funct codes with random fetch stalls
    for (int i = 0; i < 5; i++) run_r(r_tab[i].fn, r_tab[i].op, $urandom_range(0, 2));

    // lw with two MEMRD wait states: 7 cycles, exactly one register write
    opcode = 6'b100011;
    rw_cnt = 0;
    do_fetch(0);
    cycle("lw_decode", 1'b1, rz(), e_decode(1'b0));
    cycle("lw_memadr", 1'b1, rz(), e_memadr());
    cycle("lw_memrd_w", 1'b0, rz(), e_memrd());
    cycle("lw_memrd_w", 1'b0, rz(), e_memrd());
    cycle("lw_memrd", 1'b1, rz(), e_memrd());
    cycle("lw_memwb", 1'b1, rz(), e_memwb());
    check_val("lw_rw_count", 32'(rw_cnt), 32'd1);

    // sw, no wait states
    opcode = 6'b101011;
    do_fetch(0);
    cycle("sw_decode", 1'b1, rz(), e_decode(1'b0));
    cycle("sw_memadr", 1'b1, rz(), e_memadr());
    cycle("sw_memwr", 1'b1, rz(), e_memwr());

    // beq taken and not taken
    opcode = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      do_fetch(0);
      cycle("beq_decode", 1'b1, rz(), e_decode(1'b0));
      cycle("beq_branch", 1'b1, 1'(z), e_branch(1'(z)));
    end

    // j
    opcode = 6'b000010;
    do_fetch(1);
    cycle("j_decode", 1'b1, rz(), e_decode(1'b0));
    cycle("j_jump", 1'b1, rz(), e_jump());

    // ori zero-extends and ORs; addi sign-extends and adds
    opcode = 6'b001101;
    do_fetch(0);
    cycle("ori_decode", 1'b1, rz(), e_decode(1'b0));
    cycle("ori_exec", 1'b1, rz(), e_exec_i(1'b0, 4'b0011));
    cycle("ori_wb", 1'b1, rz(), e_aluwb_i());
    opcode = 6'b001000;
    do_fetch(0);
    cycle("addi_decode", 1'b1, rz(), e_decode(1'b0));
    cycle("addi_exec", 1'b1, rz(), e_exec_i(1'b1, 4'b0000));
    cycle("addi_wb", 1'b1, rz(), e_aluwb_i());

    // Illegal opcode, then illegal R funct: one-cycle pulse, straight back to FETCH
    opcode = 6'b111111;
    funct  = 6'b100000;
    do_fetch(0);
    cycle("ill_op_decode", 1'b1, rz(), e_decode(1'b1));
    opcode = 6'b000000;
    funct  = 6'b000111;
    do_fetch(0);
    cycle("ill_fn_decode", 1'b1, rz(), e_decode(1'b1));
    do_fetch(0);
    cycle("ill_fn_decode2", 1'b1, rz(), e_decode(1'b1));

    // sw interrupted by reset during a MEMWR stall
    opcode = 6'b101011;
    funct  = 6'b100000;
    do_fetch(0);
    cycle("swr_decode", 1'b1, rz(), e_decode(1'b0));
    cycle("swr_memadr", 1'b1, rz(), e_memadr());
    cycle("swr_memwr_w", 1'b0, rz(), e_memwr());
    mem_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_val("swr_mw_drop", 32'(mem_write), 32'd0);
    check_val("swr_rst_out", 32'(obs), 32'(e_fetch(1'b0)));
    @(posedge clock);
    #1;
    check_val("swr_rst_hold", 32'(obs), 32'(e_fetch(1'b0)));
    reset_n = 1'b1;
    opcode  = 6'b000000;
    run_r(6'b100010, 4'b0001, 0);
    do_fetch(0);

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
